// File: rtl/keypad_column_scanner_if.sv
// Keypad-side and consumer-side signals of the column scanner.
// The master modport is the scanner itself; slave is the pins/consumer side.
interface keypad_column_scanner_if;
    logic       en;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    modport master (
        input  en,
        input  row,
        input  key_ready,
        output col,
        output key_valid,
        output key_code
    );

    modport slave (
        output en,
        output row,
        output key_ready,
        input  col,
        input  key_valid,
        input  key_code
    );
endinterface

// File: rtl/keypad_column_scanner.sv
// Column-strobing scanner for the 4x4 elevator call keypad.
// Debounces a press per column and offers {col_idx, row_idx} over valid/ready.
module keypad_column_scanner #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned HOLD_SCANS    = 2
) (
    input logic                     clk_i,
    input logic                     n_rst_i,
    keypad_column_scanner_if.master kp_if
);

    localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned HoldW   = $clog2(HOLD_SCANS + 1);

    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [HoldW-1:0]   HoldMax    = HoldW'(HOLD_SCANS);

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSample,
        StRelDrive,
        StRelSample
    } state_e;

    state_e             state_q;
    logic [3:0]         col_q;
    logic [1:0]         col_idx_q;
    logic [SettleW-1:0] settle_q;
    logic [HoldW-1:0]   hits_q;
    logic [1:0]         cand_q;
    logic               key_valid_q;
    logic [3:0]         key_code_q;

    logic               row_any;
    logic [1:0]         row_idx;
    logic [1:0]         col_idx_inc;
    logic [3:0]         col_cur_oh;
    logic [3:0]         col_inc_oh;
    logic [HoldW-1:0]   hits_inc;
    logic [HoldW-1:0]   press_hits;
    logic [HoldW-1:0]   rel_hits;

    assign row_any     = |kp_if.row;
    assign col_idx_inc = col_idx_q + 2'd1;
    assign col_cur_oh  = 4'b0001 << col_idx_q;
    assign col_inc_oh  = 4'b0001 << col_idx_inc;

    // Lowest set row wins when several rows return on one column.
    always_comb begin
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (kp_if.row[i]) begin
                row_idx = 2'(i);
            end
        end
    end

    always_comb begin
        hits_inc   = (hits_q == HoldMax) ? HoldMax : hits_q + HoldW'(1);
        press_hits = (row_idx == cand_q) ? hits_inc : HoldW'(1);
        rel_hits   = row_any ? '0 : hits_inc;
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q     <= StIdle;
            col_q       <= '0;
            col_idx_q   <= '0;
            settle_q    <= '0;
            hits_q      <= '0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            if (key_valid_q && kp_if.key_ready) begin
                key_valid_q <= 1'b0;
            end

            if (!kp_if.en) begin
                // Pending key survives; scan progress does not.
                state_q  <= StIdle;
                col_q    <= '0;
                settle_q <= '0;
                hits_q   <= '0;
                cand_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q  <= StDrive;
                        col_q    <= col_cur_oh;
                        settle_q <= '0;
                    end

                    StDrive, StRelDrive: begin
                        if (settle_q == SettleLast) begin
                            settle_q <= '0;
                            state_q  <= (state_q == StDrive) ? StSample : StRelSample;
                        end else begin
                            settle_q <= settle_q + SettleW'(1);
                        end
                    end

                    StSample: begin
                        if (!row_any) begin
                            hits_q    <= '0;
                            col_idx_q <= col_idx_inc;
                            col_q     <= col_inc_oh;
                            state_q   <= StDrive;
                        end else begin
                            cand_q <= row_idx;
                            // A qualified press waits while an earlier code is still unaccepted.
                            if (press_hits == HoldMax && !key_valid_q) begin
                                key_code_q  <= {col_idx_q, row_idx};
                                key_valid_q <= 1'b1;
                                hits_q      <= '0;
                                state_q     <= StRelDrive;
                            end else begin
                                hits_q  <= press_hits;
                                state_q <= StDrive;
                            end
                        end
                    end

                    StRelSample: begin
                        if (rel_hits == HoldMax && !key_valid_q) begin
                            hits_q    <= '0;
                            col_idx_q <= col_idx_inc;
                            col_q     <= col_inc_oh;
                            state_q   <= StDrive;
                        end else begin
                            hits_q  <= rel_hits;
                            state_q <= StRelDrive;
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                        col_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign kp_if.col       = col_q;
    assign kp_if.key_valid = key_valid_q;
    assign kp_if.key_code  = key_code_q;

    col_onehot_a: assert property (@(posedge clk_i) disable iff (!n_rst_i) $onehot0(col_q));

    key_hold_a: assert property (@(posedge clk_i) disable iff (!n_rst_i)
        key_valid_q && !kp_if.key_ready |=> key_valid_q && $stable(key_code_q));

endmodule
